bpred_update_ctrl: RTL and testbench

BPRED_UPDATE_CTRL -- requirements
Module: bpred_update_ctrl

---
 rtl/bpred_update_ctrl_pkg.sv | 26 ++
 rtl/bpred_upd_fifo.sv | 53 +++++
 rtl/bpred_update_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_bpred_update_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_update_ctrl_pkg.sv
// Shared branch-predictor constants: default BTB/PT geometry, update FSM
// state encoding and the 2-bit saturating counter step.
package bpred_update_ctrl_pkg;

  localparam int unsigned PTINDEXBITS_DEF  = 8;
  localparam int unsigned BTBINDEXBITS_DEF = 6;
  localparam int unsigned TAGBITS_DEF      = 26;  // PC[31:6]
  localparam int unsigned DBITS_DEF        = 32;
  localparam int unsigned QDEPTH_DEF       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RMW_RD = 2'd1,
    ST_RMW_WR = 2'd2
  } bpred_state_e;

  // Move a 2-bit counter toward taken/not-taken, saturating at 3 and 0.
  function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != 2'd3)) nxt = ctr + 2'd1;
    else if (!taken && (ctr != 2'd0)) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Resolved-branch update queue. DEPTH must be a power of two (>= 2);
// full/empty come from an occupancy count one bit wider than the pointers.
module bpred_upd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Entry storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally at DEPTH; simultaneous push/pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bpred_update_ctrl.sv
// Branch-predictor update controller: arbitrates the single-port PT/BTB
// SRAMs between front-end lookups (priority) and queued read-modify-write
// updates from resolved branches, and maintains the global history.
module bpred_update_ctrl
  import bpred_update_ctrl_pkg::*;
#(
  parameter int unsigned PTINDEXBITS  = PTINDEXBITS_DEF,
  parameter int unsigned BTBINDEXBITS = BTBINDEXBITS_DEF,
  parameter int unsigned TAGBITS      = TAGBITS_DEF,
  parameter int unsigned DBITS        = DBITS_DEF,
  parameter int unsigned QDEPTH       = QDEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fe_lkp_valid,
  output logic                     fe_lkp_ready,
  input  logic [PTINDEXBITS-1:0]   fe_lkp_pt_idx,
  input  logic [BTBINDEXBITS-1:0]  fe_lkp_btb_idx,
  output logic                     fe_rsp_valid,
  output logic [1:0]               fe_rsp_ctr,
  output logic [TAGBITS-1:0]       fe_rsp_tag,
  output logic [DBITS-1:0]         fe_rsp_target,
  input  logic                     upd_valid,
  output logic                     upd_ready,
  input  logic [PTINDEXBITS-1:0]   upd_pt_idx,
  input  logic [BTBINDEXBITS-1:0]  upd_btb_idx,
  input  logic [TAGBITS-1:0]       upd_tag,
  input  logic [DBITS-1:0]         upd_target,
  input  logic                     upd_taken,
  output logic [7:0]               bhr,
  output logic                     pt_en,
  output logic                     pt_we,
  output logic [PTINDEXBITS-1:0]   pt_addr,
  output logic [1:0]               pt_wdata,
  input  logic [1:0]               pt_rdata,
  output logic                     btb_en,
  output logic                     btb_we,
  output logic [BTBINDEXBITS-1:0]  btb_addr,
  output logic [TAGBITS+DBITS-1:0] btb_wdata,
  input  logic [TAGBITS+DBITS-1:0] btb_rdata,
  output logic [DBITS-1:0]         upd_count,
  output logic [DBITS-1:0]         lkp_stall_count
);

  localparam int unsigned REC_W = PTINDEXBITS + BTBINDEXBITS + TAGBITS + DBITS + 1;

  bpred_state_e state_q, state_d;

  logic [REC_W-1:0]  hold_q, hold_d;
  logic [1:0]        ctr_q, ctr_d;
  logic [7:0]        bhr_q;
  logic [DBITS-1:0]  upd_count_q, lkp_stall_q;
  logic              rsp_valid_q;

  logic              q_full, q_empty, q_pop, upd_accept, lkp_accept, cnt_inc;
  logic [REC_W-1:0]  q_head;

  logic [PTINDEXBITS-1:0]  hold_pt;
  logic [BTBINDEXBITS-1:0] hold_btb;
  logic [TAGBITS-1:0]      hold_tag;
  logic [DBITS-1:0]        hold_tgt;
  logic                    hold_taken;

  assign {hold_pt, hold_btb, hold_tag, hold_tgt, hold_taken} = hold_q;

  assign upd_ready  = !q_full;
  assign upd_accept = upd_valid && upd_ready;

  bpred_upd_fifo #(
    .WIDTH (REC_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (upd_accept),
    .wdata_i ({upd_pt_idx, upd_btb_idx, upd_tag, upd_target, upd_taken}),
    .pop_i   (q_pop),
    .rdata_o (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Port arbitration and RMW sequencing; SRAM ports held idle during reset.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    ctr_d        = ctr_q;
    fe_lkp_ready = 1'b0;
    lkp_accept   = 1'b0;
    q_pop        = 1'b0;
    cnt_inc      = 1'b0;
    pt_en        = 1'b0;
    pt_we        = 1'b0;
    pt_addr      = '0;
    pt_wdata     = '0;
    btb_en       = 1'b0;
    btb_we       = 1'b0;
    btb_addr     = '0;
    btb_wdata    = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          fe_lkp_ready = 1'b1;
          if (fe_lkp_valid) begin
            lkp_accept = 1'b1;
            pt_en      = 1'b1;
            pt_addr    = fe_lkp_pt_idx;
            btb_en     = 1'b1;
            btb_addr   = fe_lkp_btb_idx;
          end else if (!q_empty) begin
            q_pop   = 1'b1;
            hold_d  = q_head;
            pt_en   = 1'b1;
            pt_addr = q_head[REC_W-1 -: PTINDEXBITS];
            state_d = ST_RMW_RD;
          end
        end
        ST_RMW_RD: begin
          // Capture the counter in its valid cycle so the write does not
          // depend on the SRAM holding its output an extra cycle.
          ctr_d   = pt_rdata;
          state_d = ST_RMW_WR;
        end
        ST_RMW_WR: begin
          pt_en     = 1'b1;
          pt_we     = 1'b1;
          pt_addr   = hold_pt;
          pt_wdata  = sat_ctr_next(ctr_q, hold_taken);
          btb_en    = 1'b1;
          btb_we    = 1'b1;
          btb_addr  = hold_btb;
          btb_wdata = {hold_tag, hold_tgt};
          cnt_inc   = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Holding register for the in-flight update and its read counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      ctr_q  <= '0;
    end else begin
      hold_q <= hold_d;
      ctr_q  <= ctr_d;
    end
  end

  // History, statistics counters and the lookup response strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      bhr_q       <= '0;
      upd_count_q <= '0;
      lkp_stall_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (upd_accept) bhr_q <= {bhr_q[6:0], upd_taken};
      if (cnt_inc) upd_count_q <= upd_count_q + 1'b1;
      if (fe_lkp_valid && !fe_lkp_ready) lkp_stall_q <= lkp_stall_q + 1'b1;
      rsp_valid_q <= lkp_accept;
    end
  end

  assign bhr             = bhr_q;
  assign upd_count       = upd_count_q;
  assign lkp_stall_count = lkp_stall_q;
  assign fe_rsp_valid    = rsp_valid_q;
  assign fe_rsp_ctr      = rsp_valid_q ? pt_rdata : '0;
  assign fe_rsp_tag      = rsp_valid_q ? btb_rdata[TAGBITS+DBITS-1:DBITS] : '0;
  assign fe_rsp_target   = rsp_valid_q ? btb_rdata[DBITS-1:0] : '0;

endmodule

// File: tb/tb_bpred_update_ctrl.sv
// Scoreboard bench for bpred_update_ctrl with behavioural PT/BTB SRAMs.
module tb_bpred_update_ctrl;

  logic        clk;
  logic        reset;
  logic        fe_lkp_valid, fe_lkp_ready;
  logic [7:0]  fe_lkp_pt_idx;
  logic [5:0]  fe_lkp_btb_idx;
  logic        fe_rsp_valid;
  logic [1:0]  fe_rsp_ctr;
  logic [25:0] fe_rsp_tag;
  logic [31:0] fe_rsp_target;
  logic        upd_valid, upd_ready;
  logic [7:0]  upd_pt_idx;
  logic [5:0]  upd_btb_idx;
  logic [25:0] upd_tag;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [7:0]  bhr;
  logic        pt_en, pt_we;
  logic [7:0]  pt_addr;
  logic [1:0]  pt_wdata;
  logic [1:0]  pt_rdata = '0;
  logic        btb_en, btb_we;
  logic [5:0]  btb_addr;
  logic [57:0] btb_wdata;
  logic [57:0] btb_rdata = '0;
  logic [31:0] upd_count, lkp_stall_count;

  int checks = 0;
  int errors = 0;

  bpred_update_ctrl #(
    .PTINDEXBITS  (8),
    .BTBINDEXBITS (6),
    .TAGBITS      (26),
    .DBITS        (32),
    .QDEPTH       (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fe_lkp_valid    (fe_lkp_valid),
    .fe_lkp_ready    (fe_lkp_ready),
    .fe_lkp_pt_idx   (fe_lkp_pt_idx),
    .fe_lkp_btb_idx  (fe_lkp_btb_idx),
    .fe_rsp_valid    (fe_rsp_valid),
    .fe_rsp_ctr      (fe_rsp_ctr),
    .fe_rsp_tag      (fe_rsp_tag),
    .fe_rsp_target   (fe_rsp_target),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_pt_idx      (upd_pt_idx),
    .upd_btb_idx     (upd_btb_idx),
    .upd_tag         (upd_tag),
    .upd_target      (upd_target),
    .upd_taken       (upd_taken),
    .bhr             (bhr),
    .pt_en           (pt_en),
    .pt_we           (pt_we),
    .pt_addr         (pt_addr),
    .pt_wdata        (pt_wdata),
    .pt_rdata        (pt_rdata),
    .btb_en          (btb_en),
    .btb_we          (btb_we),
    .btb_addr        (btb_addr),
    .btb_wdata       (btb_wdata),
    .btb_rdata       (btb_rdata),
    .upd_count       (upd_count),
    .lkp_stall_count (lkp_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten SRAM words read back a fixed pattern of their address.
  function automatic logic [1:0] pt_init(input logic [7:0] a);
    return a[1:0] ^ 2'b10;
  endfunction
  function automatic logic [57:0] btb_init(input logic [5:0] a);
    return {26'(a) + 26'h100, 32'hA000_0000 | 32'(a)};
  endfunction

  logic [1:0]  pt_mem  [256];
  bit          pt_wr   [256];
  logic [57:0] btb_mem [64];
  bit          btb_wr  [64];

  always @(posedge clk) begin
    if (pt_en) begin
      if (pt_we) begin
        pt_mem[pt_addr] <= pt_wdata;
        pt_wr[pt_addr]  <= 1'b1;
      end else begin
        pt_rdata <= pt_wr[pt_addr] ? pt_mem[pt_addr] : pt_init(pt_addr);
      end
    end
    if (btb_en) begin
      if (btb_we) begin
        btb_mem[btb_addr] <= btb_wdata;
        btb_wr[btb_addr]  <= 1'b1;
      end else begin
        btb_rdata <= btb_wr[btb_addr] ? btb_mem[btb_addr] : btb_init(btb_addr);
      end
    end
  end

  typedef struct packed {
    logic [7:0]  pa;
    logic [1:0]  pd;
    logic [5:0]  ba;
    logic [57:0] bd;
  } wr_t;

  typedef struct packed {
    logic [1:0]  ctr;
    logic [25:0] tag;
    logic [31:0] tgt;
  } rsp_t;

  wr_t  wq[$];
  rsp_t rq[$];
  wr_t  w_exp;
  rsp_t r_exp;

  // Lookups always use pt 7 / btb 40, never touched by updates.
  localparam logic [7:0]  LKP_PT  = 8'd7;
  localparam logic [5:0]  LKP_BTB = 6'd40;
  localparam rsp_t        LKP_RSP = '{ctr: 2'd1, tag: 26'h128, tgt: 32'hA000_0028};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: compare SRAM writes and lookup responses against the queues,
  // then record newly accepted lookups.
  always @(negedge clk) begin
    if (pt_en && pt_we) begin
      if (wq.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        w_exp = wq.pop_front();
        chk("pt_addr",   64'(pt_addr),   64'(w_exp.pa));
        chk("pt_wdata",  64'(pt_wdata),  64'(w_exp.pd));
        chk("btb_wr_en", 64'({btb_en, btb_we}), 64'(2'b11));
        chk("btb_addr",  64'(btb_addr),  64'(w_exp.ba));
        chk("btb_wdata", 64'(btb_wdata), 64'(w_exp.bd));
      end
    end else if (btb_en && btb_we) begin
      fail_now("btb_write_without_pt");
    end
    if (fe_rsp_valid) begin
      if (rq.size() == 0) begin
        fail_now("unexpected_rsp");
      end else begin
        r_exp = rq.pop_front();
        chk("rsp_ctr",    64'(fe_rsp_ctr),    64'(r_exp.ctr));
        chk("rsp_tag",    64'(fe_rsp_tag),    64'(r_exp.tag));
        chk("rsp_target", 64'(fe_rsp_target), 64'(r_exp.tgt));
      end
    end else if (rq.size() != 0) begin
      fail_now("missing_rsp");
      rq.delete();
    end
    if (fe_lkp_valid && fe_lkp_ready) rq.push_back(LKP_RSP);
  end

  task automatic drive_upd(input logic [7:0] p, input logic [5:0] b, input logic [25:0] tg,
                           input logic [31:0] tt, input logic tk);
    upd_pt_idx  = p;
    upd_btb_idx = b;
    upd_tag     = tg;
    upd_target  = tt;
    upd_taken   = tk;
    upd_valid   = 1'b1;
  endtask

  task automatic finish_upd(input logic exp_wr, input logic [1:0] exp_pd);
    int n;
    n = 0;
    @(negedge clk);
    while (!upd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!upd_ready) fail_now("upd_accept_timeout");
    else if (exp_wr) wq.push_back('{pa: upd_pt_idx, pd: exp_pd, ba: upd_btb_idx, bd: {upd_tag, upd_target}});
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  task automatic send_upd(input logic [7:0] p, input logic [5:0] b, input logic [25:0] tg,
                          input logic [31:0] tt, input logic tk, input logic exp_wr,
                          input logic [1:0] exp_pd);
    drive_upd(p, b, tg, tt, tk);
    finish_upd(exp_wr, exp_pd);
  endtask

  task automatic wait_count(input logic [31:0] target);
    int n;
    n = 0;
    @(negedge clk);
    while (upd_count !== target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("upd_count", 64'(upd_count), 64'(target));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    fe_lkp_valid   = 1'b1;
    fe_lkp_pt_idx  = LKP_PT;
    fe_lkp_btb_idx = LKP_BTB;
    upd_valid      = 1'b0;
    upd_pt_idx     = '0;
    upd_btb_idx    = '0;
    upd_tag        = '0;
    upd_target     = '0;
    upd_taken      = 1'b0;

    // Reset cycle: SRAM ports idle even with a lookup pending.
    @(negedge clk);
    chk("rst_pt_en",  64'(pt_en),  64'd0);
    chk("rst_btb_en", 64'(btb_en), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    fe_lkp_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_rsp_valid", 64'(fe_rsp_valid), 64'd0);
    chk("idle_rsp_data",  64'({fe_rsp_ctr, fe_rsp_tag, fe_rsp_target}), 64'd0);
    chk("idle_bhr",       64'(bhr), 64'd0);
    chk("idle_upd_count", 64'(upd_count), 64'd0);
    chk("idle_stall",     64'(lkp_stall_count), 64'd0);
    chk("idle_sram_en",   64'({pt_en, pt_we, btb_en, btb_we}), 64'd0);
    chk("idle_upd_ready", 64'(upd_ready), 64'd1);
    chk("idle_lkp_ready", 64'(fe_lkp_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single update, counter already saturated high.
    send_upd(8'd5, 6'd9, 26'h2ABCDEF, 32'h8000_1234, 1'b1, 1'b1, 2'd3);
    wait_count(32'd1);
    chk("bhr_1", 64'(bhr), 64'h01);

    // Saturation low, increment, decrement.
    send_upd(8'd10, 6'd10, 26'h0000010, 32'h0000_0100, 1'b0, 1'b1, 2'd0);
    send_upd(8'd11, 6'd11, 26'h0000011, 32'h0000_0110, 1'b1, 1'b1, 2'd2);
    send_upd(8'd12, 6'd12, 26'h0000012, 32'h0000_0120, 1'b0, 1'b1, 2'd1);
    wait_count(32'd4);
    chk("bhr_4", 64'(bhr), 64'h0A);

    // Single lookup.
    fe_lkp_valid = 1'b1;
    @(posedge clk);
    #1 fe_lkp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Queue fills while lookups keep the port busy.
    fe_lkp_valid = 1'b1;
    send_upd(8'd20, 6'd20, 26'h0000020, 32'h0000_0200, 1'b1, 1'b1, 2'd3);
    send_upd(8'd21, 6'd21, 26'h0000021, 32'h0000_0210, 1'b1, 1'b1, 2'd3);
    send_upd(8'd22, 6'd22, 26'h0000022, 32'h0000_0220, 1'b0, 1'b1, 2'd0);
    send_upd(8'd23, 6'd23, 26'h0000023, 32'h0000_0230, 1'b0, 1'b1, 2'd0);
    drive_upd(8'd24, 6'd24, 26'h0000024, 32'h0000_0240, 1'b1);
    @(negedge clk);
    chk("upd_ready_full", 64'(upd_ready), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("no_pop_during_lkp", 64'(upd_ready), 64'd0);
    chk("stall_while_busy",  64'(lkp_stall_count), 64'd0);
    @(posedge clk);
    #1 fe_lkp_valid = 1'b0;
    finish_upd(1'b1, 2'd3);
    wait_count(32'd9);
    chk("bhr_9", 64'(bhr), 64'h59);

    // One queued update, lookup dropped for a cycle then reasserted.
    fe_lkp_valid = 1'b1;
    send_upd(8'd25, 6'd25, 26'h0000025, 32'h0000_0250, 1'b1, 1'b1, 2'd3);
    repeat (2) @(posedge clk);
    #1 fe_lkp_valid = 1'b0;
    @(negedge clk);
    chk("ready_at_pop", 64'(fe_lkp_ready), 64'd1);
    @(posedge clk);
    #1 fe_lkp_valid = 1'b1;
    @(negedge clk);
    chk("ready_rmw_rd", 64'(fe_lkp_ready), 64'd0);
    @(negedge clk);
    chk("ready_rmw_wr", 64'(fe_lkp_ready), 64'd0);
    @(negedge clk);
    chk("ready_back",   64'(fe_lkp_ready), 64'd1);
    @(posedge clk);
    #1 fe_lkp_valid = 1'b0;
    @(negedge clk);
    chk("stall_count_2", 64'(lkp_stall_count), 64'd2);
    chk("bhr_10", 64'(bhr), 64'hB3);
    @(posedge clk);
    #1;
    wait_count(32'd10);

    // Reset while an update sits in RMW_RD and another is queued.
    send_upd(8'd30, 6'd30, 26'h0000030, 32'h0000_0300, 1'b1, 1'b0, 2'd0);
    send_upd(8'd31, 6'd31, 26'h0000031, 32'h0000_0310, 1'b1, 1'b0, 2'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rmw_en", 64'({pt_en, btb_en}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("post_rst_upd_count", 64'(upd_count), 64'd0);
    chk("post_rst_bhr",       64'(bhr), 64'd0);
    chk("post_rst_upd_ready", 64'(upd_ready), 64'd1);
    chk("post_rst_lkp_ready", 64'(fe_lkp_ready), 64'd1);
    chk("post_rst_rsp_valid", 64'(fe_rsp_valid), 64'd0);
    chk("wq_drained", 64'(wq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
